accum_unit: RTL and testbench

ACCUM_UNIT -- requirements
Module: accum_unit

---
 rtl/accum_unit_pkg.sv | 16 +
 rtl/accum_unit_adder.sv | 25 ++
 rtl/accum_unit.sv | 104 ++++++++++
 tb/tb_accum_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/accum_unit_pkg.sv
// Shared definitions for the accumulator unit.
//   state_t    : controller states (IDLE, ACC, DONE)
//   DEF_WIDTH  : default operand / sum width
//   DEF_LEN_W  : default width of the operand-count and carry-count fields
package accum_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LEN_W = 8;

endpackage

// File: rtl/accum_unit_adder.sv
// 32-bit ripple-carry adder used as the accumulator datapath.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^32
//   cout : carry out of bit 31
module thirtytwobitadder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[32];

endmodule

// File: rtl/accum_unit.sv
// Accumulator unit: sums a programmed number of operands and reports the
// modulo-2^WIDTH sum together with a saturating count of adder carry-outs.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, len           : begin a run of len operands (sampled in IDLE only)
//   in_valid/in_ready    : operand handshake, in_data is the operand
//   out_valid/out_ready  : result handshake
//   out_sum, out_carries : live accumulator and carry count
//   busy                 : high whenever the controller is not idle
module accum_unit
  import accum_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [LEN_W-1:0] out_carries,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   carries_q, carries_d;
  logic [LEN_W-1:0]   remain_q, remain_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  // The adder always sees the live accumulator; its result is only used on
  // a transfer cycle.
  thirtytwobitadder u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      carries_q <= '0;
      remain_q  <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      carries_q <= carries_d;
      remain_q  <= remain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carries_d = carries_q;
    remain_d  = remain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d     = '0;
          carries_d = '0;
          remain_d  = len;
          // A zero-length run produces an immediate zero result.
          state_d   = (len == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          acc_d    = add_sum;
          remain_d = remain_q - 1'b1;
          // Carry count sticks at all-ones rather than wrapping.
          if (add_cout && (carries_q != {LEN_W{1'b1}})) begin
            carries_d = carries_q + 1'b1;
          end
          if (remain_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready    = (state_q == ST_ACC);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign out_sum     = acc_q;
  assign out_carries = carries_q;

endmodule

// File: tb/tb_accum_unit.sv
module tb_accum_unit;

  localparam int WIDTH = 32;
  localparam int LEN_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [LEN_W-1:0] car;
  } result_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [LEN_W-1:0] out_carries;
  logic             busy;

  result_t          sb_q[$];
  int               n_asserts = 0;
  int               n_fails   = 0;

  // Reference model state, rebuilt independently of the DUT.
  logic [WIDTH-1:0] m_acc;
  logic [LEN_W-1:0] m_car;

  accum_unit #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks begin and end just after a falling edge.
  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    m_acc = '0;
    m_car = '0;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input int gap);
    logic [WIDTH:0] s;
    check("in_ready_acc", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    s = {1'b0, m_acc} + {1'b0, d};
    m_acc = s[WIDTH-1:0];
    if (s[WIDTH] && (m_car != {LEN_W{1'b1}})) m_car = m_car + 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("busy_gap", {63'd0, busy}, 64'd1);
      check("hold_gap", {32'd0, out_sum}, {32'd0, m_acc});
    end
  endtask

  task automatic expect_result(input string tag);
    int      waited;
    result_t e;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_latency"}, 64'(waited), 64'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_sum"}, {32'd0, out_sum}, {32'd0, e.sum});
      check({tag, "_carries"}, {56'd0, out_carries}, {56'd0, e.car});
    end
  endtask

  task automatic release_result(input string tag, input int hold, input logic pulse);
    logic [WIDTH-1:0] s0;
    logic [LEN_W-1:0] c0;
    s0 = out_sum;
    c0 = out_carries;
    for (int i = 0; i < hold; i++) begin
      start = pulse;
      len   = 8'd3;
      @(negedge clk);
      check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_hold_sum"}, {32'd0, out_sum}, {32'd0, s0});
      check({tag, "_hold_car"}, {56'd0, out_carries}, {56'd0, c0});
    end
    start     = pulse;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_acc     = '0;
    m_car     = '0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sum", {32'd0, out_sum}, 64'd0);
    check("rst_carries", {56'd0, out_carries}, 64'd0);
    rst_n = 1'b1;

    // Two small operands, start on the first edge after reset.
    do_start(8'd2);
    check("t1_busy", {63'd0, busy}, 64'd1);
    send(32'd10, 0);
    send(32'd10, 0);
    sb_q.push_back('{sum: 32'd20, car: 8'd0});
    expect_result("t1");
    release_result("t1", 0, 1'b0);

    // Operands with input gaps.
    do_start(8'd3);
    send(32'd200, 2);
    send(32'd750, 2);
    send(32'd1234, 0);
    sb_q.push_back('{sum: 32'd2184, car: 8'd0});
    expect_result("t2");
    release_result("t2", 0, 1'b0);

    // Wrap-around with a single carry-out.
    do_start(8'd2);
    send(32'hFFFF_FFFF, 0);
    send(32'h0000_0002, 0);
    sb_q.push_back('{sum: 32'd1, car: 8'd1});
    expect_result("t3");
    release_result("t3", 0, 1'b0);

    // Zero-length run, consumer stalls with start pulses, start at handshake.
    do_start(8'd0);
    sb_q.push_back('{sum: 32'd0, car: 8'd0});
    expect_result("t4");
    release_result("t4", 5, 1'b1);

    // Reset mid-run abandons it.
    do_start(8'd4);
    send(32'd111, 0);
    send(32'd222, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_sum", {32'd0, out_sum}, 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    check("t5_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(8'd1);
    send(32'd5678, 0);
    sb_q.push_back('{sum: 32'd5678, car: 8'd0});
    expect_result("t5");
    release_result("t5", 0, 1'b0);

    // Pseudo-random operands checked against the model.
    do_start(8'd6);
    for (int i = 0; i < 6; i++) send($urandom(), (i == 2) ? 1 : 0);
    sb_q.push_back('{sum: m_acc, car: m_car});
    expect_result("t6");
    release_result("t6", 1, 1'b0);

    // Maximum length, every add after the first carries.
    do_start(8'd255);
    for (int i = 0; i < 255; i++) send(32'hFFFF_FFFF, 0);
    sb_q.push_back('{sum: 32'hFFFF_FF01, car: 8'd254});
    expect_result("t7");
    release_result("t7", 0, 1'b0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
